// File: rtl/key_debounce_edge_ctrl.sv
// key_debounce_edge_ctrl
//   Avalon-MM slave that conditions the board push-keys before software sees
//   them. Each key is synchronised (2 FFs), debounced by a per-key counter,
//   and debounced press edges are latched in a write-1-to-clear register.
//   A maskable level interrupt is raised while any unmasked captured edge is
//   pending. The register map mirrors the stock PIO core so existing drivers
//   keep working:
//     0 data (debounced key levels, read only)
//     1 reserved (reads 0, writes ignored)
//     2 irqmask
//     3 edgecapture (write 1 to clear)
//   Read data is registered: the value for 'address' appears one clock later,
//   independent of chipselect.

module key_debounce_edge_ctrl #(
  parameter int unsigned WIDTH           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Word addresses of the register map.
  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_RSVD    = 2'd1,
    ADDR_IRQMASK = 2'd2,
    ADDR_EDGECAP = 2'd3
  } reg_addr_e;

  // Level of an idle (released) key on every bit.
  localparam logic [WIDTH-1:0] RELEASED = {WIDTH{ACTIVE_LOW}};

  // Terminal count: a change is accepted on the DEBOUNCE_CYCLES-th
  // consecutive mismatching sample, so the counter tops out one below that.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Synchroniser: in_port -> sync1 -> sync2. Only sync2 is used downstream.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sync1_d, sync1_q;
  logic [WIDTH-1:0] sync2_d, sync2_q;

  // Next values of the synchroniser stages.
  always_comb begin
    sync1_d = in_port;
    sync2_d = sync1_q;
  end

  // Synchroniser stages; reset to the released level so no fake edge appears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= RELEASED;
      sync2_q <= RELEASED;
    end else begin
      // NOTE: non-blocking assignments make both stages sample the values
      // from before this edge; blocking here would collapse the two FFs into
      // one and defeat the metastability filter.
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: one counter per key, counting consecutive samples where sync2
  // disagrees with the accepted (stable) level. Any agreeing sample restarts
  // the count, so a bounce pushes acceptance out by a full window.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]            stable_d, stable_q;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_d, cnt_q;
  logic [WIDTH-1:0]            press_evt;

  // Next stable level and counter value per key, plus press-event detection.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch;
    // leaving one unassigned on some path would infer a latch.
    stable_d = stable_q;
    cnt_d    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
    // A press is the stable level leaving the released level this cycle;
    // the opposite (release) transition is deliberately not reported.
    if (ACTIVE_LOW) begin
      press_evt = stable_q & ~stable_d;
    end else begin
      press_evt = ~stable_q & stable_d;
    end
  end

  // Debounce state; reset aborts any count in progress and forces released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= RELEASED;
      // NOTE: the counters are an array of flops, not a RAM, so resetting
      // every entry is free and required for a clean restart.
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file: irqmask and edgecapture.
  // ---------------------------------------------------------------------------
  logic             wr_en;
  logic [WIDTH-1:0] irqmask_d, irqmask_q;
  logic [WIDTH-1:0] edgecap_d, edgecap_q;
  logic [WIDTH-1:0] edgecap_clr;

  // Bits of the write bus above the key width carry no meaning here.
  logic unused_wdata;
  assign unused_wdata = ^writedata[31:WIDTH];

  // Write decode; a press and a clear hitting one bit together keep the bit
  // set so a press is never lost to a racing software acknowledge.
  always_comb begin
    wr_en       = chipselect & ~write_n;
    irqmask_d   = irqmask_q;
    edgecap_clr = '0;
    if (wr_en && (reg_addr_e'(address) == ADDR_IRQMASK)) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && (reg_addr_e'(address) == ADDR_EDGECAP)) begin
      edgecap_clr = writedata[WIDTH-1:0];
    end
    edgecap_d = (edgecap_q & ~edgecap_clr) | press_evt;
  end

  // Software-visible control/status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q <= '0;
      edgecap_q <= '0;
    end else begin
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: registered mux, updated every cycle regardless of chipselect.
  // ---------------------------------------------------------------------------
  logic [31:0] readdata_d, readdata_q;

  // Select the addressed register, zero-extended to the bus width.
  always_comb begin
    readdata_d = '0;
    case (reg_addr_e'(address))
      ADDR_DATA:    readdata_d = 32'(stable_q);
      ADDR_RSVD:    readdata_d = '0;
      ADDR_IRQMASK: readdata_d = 32'(irqmask_q);
      ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
      default:      readdata_d = '0;
    endcase
  end

  // Read data register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
    end else begin
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;

  // Interrupt is built only from registered state, so it cannot glitch.
  assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_key_debounce_edge_ctrl.sv
// Directed testbench for key_debounce_edge_ctrl with a short debounce window
// (DEBOUNCE_CYCLES=4) so latencies can be checked cycle by cycle.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.

module tb_key_debounce_edge_ctrl;

  localparam int unsigned WIDTH = 2;
  localparam int unsigned DB    = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] in_port;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic             irq;

  int errors = 0;
  int checks = 0;

  key_debounce_edge_ctrl #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (CNT_W),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_port   (in_port),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and land 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Single-cycle bus write; takes effect on the next rising edge.
  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  // Registered read: value of the register as it was before the next edge.
  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    address = addr;
    tick(1);
    data = readdata;
  endtask

  // Reset values on every register and on irq.
  task automatic test_reset();
    logic [31:0] rd;
    reset_n    = 1'b0;
    in_port    = 2'b11;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    #2;
    checks++;
    if (readdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_readdata: got 0x%0h expected 0x0", readdata);
    end
    tick(3);
    reset_n = 1'b1;
    bus_read(2'd0, rd);
    checks++;
    if (rd !== 32'h3) begin
      errors++;
      $display("FAIL reset_data: got 0x%0h expected 0x3", rd);
    end
    bus_read(2'd2, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL reset_irqmask: got 0x%0h expected 0x0", rd);
    end
    bus_read(2'd3, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL reset_edgecap: got 0x%0h expected 0x0", rd);
    end
    bus_read(2'd1, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL reset_reserved: got 0x%0h expected 0x0", rd);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: got %0b expected 0", irq);
    end
  endtask

  // Clean press on key 0: stable flips on edge 6, visible on readdata at 7.
  task automatic test_press_latency();
    logic [31:0] rd;
    logic [31:0] exp;
    address    = 2'd0;
    in_port[0] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      exp = (k <= 6) ? 32'h3 : 32'h2;
      checks++;
      if (readdata !== exp) begin
        errors++;
        $display("FAIL press_latency edge %0d: got 0x%0h expected 0x%0h", k, readdata, exp);
      end
    end
    bus_read(2'd3, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("FAIL press_edgecap: got 0x%0h expected 0x1", rd);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL press_irq_masked: got %0b expected 0", irq);
    end
    bus_write(2'd3, 32'h1);
    in_port[0] = 1'b1;
    tick(8);
    bus_read(2'd3, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL release_ignored: got 0x%0h expected 0x0", rd);
    end
    bus_read(2'd0, rd);
    checks++;
    if (rd !== 32'h3) begin
      errors++;
      $display("FAIL release_data: got 0x%0h expected 0x3", rd);
    end
  endtask

  // Key 0 low for 3 samples, high for 1, then low: the count restarts and
  // stable flips on edge 10 (4 samples after the bounce clears the sync).
  task automatic test_bounce();
    logic [31:0] rd;
    logic [31:0] exp;
    address = 2'd0;
    for (int k = 1; k <= 11; k++) begin
      in_port[0] = (k == 4);
      tick(1);
      exp = (k <= 10) ? 32'h3 : 32'h2;
      checks++;
      if (readdata !== exp) begin
        errors++;
        $display("FAIL bounce edge %0d: got 0x%0h expected 0x%0h", k, readdata, exp);
      end
    end
    bus_read(2'd3, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("FAIL bounce_edgecap: got 0x%0h expected 0x1", rd);
    end
    bus_write(2'd3, 32'h1);
    in_port = 2'b11;
    tick(8);
  endtask

  // Masked interrupt: assert timing, W1C deassert, mask-driven assert/deassert.
  task automatic test_irq();
    logic [31:0] rd;
    bus_write(2'd2, 32'hFFFF_FFFD);
    bus_read(2'd2, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("FAIL irqmask_width: got 0x%0h expected 0x1", rd);
    end
    in_port[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      checks++;
      if (irq !== (k >= 6)) begin
        errors++;
        $display("FAIL irq_assert edge %0d: got %0b expected %0b", k, irq, (k >= 6));
      end
    end
    bus_write(2'd3, 32'h1);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_w1c_deassert: got %0b expected 0", irq);
    end
    bus_read(2'd3, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL w1c_edgecap: got 0x%0h expected 0x0", rd);
    end
    in_port = 2'b11;
    tick(8);
    in_port = 2'b01;
    tick(8);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_other_bit_masked: got %0b expected 0", irq);
    end
    bus_read(2'd3, rd);
    checks++;
    if (rd !== 32'h2) begin
      errors++;
      $display("FAIL key1_edgecap: got 0x%0h expected 0x2", rd);
    end
    bus_write(2'd2, 32'h2);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_mask_assert: got %0b expected 1", irq);
    end
    bus_write(2'd2, 32'h0);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_mask_deassert: got %0b expected 0", irq);
    end
    bus_write(2'd3, 32'h3);
    in_port = 2'b11;
    tick(8);
  endtask

  // W1C on bit 1 lands on the same edge the key-1 press is captured.
  task automatic test_set_clear_race();
    logic [31:0] rd;
    bus_write(2'd2, 32'h2);
    in_port[1] = 1'b0;
    tick(5);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL race_pre_irq: got %0b expected 0", irq);
    end
    bus_write(2'd3, 32'h2);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL race_irq: got %0b expected 1", irq);
    end
    bus_read(2'd3, rd);
    checks++;
    if (rd !== 32'h2) begin
      errors++;
      $display("FAIL race_edgecap: got 0x%0h expected 0x2", rd);
    end
    bus_write(2'd3, 32'h2);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL race_clear_irq: got %0b expected 0", irq);
    end
    in_port = 2'b11;
    tick(8);
  endtask

  // Reset while key 0's counter sits at 2: all state clears immediately and
  // the still-held key needs a full 2+4 cycles after reset release.
  task automatic test_reset_mid_debounce();
    logic [31:0] rd;
    logic [31:0] exp;
    address    = 2'd0;
    in_port[0] = 1'b0;
    tick(4);
    checks++;
    if (readdata !== 32'h3) begin
      errors++;
      $display("FAIL mid_pre_reset: got 0x%0h expected 0x3", readdata);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (readdata !== 32'h0) begin
      errors++;
      $display("FAIL mid_async_readdata: got 0x%0h expected 0x0", readdata);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL mid_async_irq: got %0b expected 0", irq);
    end
    tick(1);
    reset_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      exp = (k <= 6) ? 32'h3 : 32'h2;
      checks++;
      if (readdata !== exp) begin
        errors++;
        $display("FAIL mid_restart edge %0d: got 0x%0h expected 0x%0h", k, readdata, exp);
      end
    end
    bus_read(2'd2, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL mid_irqmask: got 0x%0h expected 0x0", rd);
    end
    bus_read(2'd3, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("FAIL mid_edgecap: got 0x%0h expected 0x1", rd);
    end
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_bounce();
    test_irq();
    test_set_clear_race();
    test_reset_mid_debounce();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
